// File: rtl/montar_pin_if.sv
// PIN packet type and the key/packet bus between the keypad front end and montar_pin.
// The packet is consumed downstream by the password-check stage.
package montar_pin_pkg;
    localparam logic [3:0] BLANK = 4'hA;

    typedef struct packed {
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
        logic       status;
    } pinPac_t;

    localparam pinPac_t BLANK_PAC = '{digit1: BLANK, digit2: BLANK, digit3: BLANK,
                                      digit4: BLANK, status: 1'b0};
endpackage

interface montar_pin_if;
    import montar_pin_pkg::*;

    logic       enable;
    logic [3:0] key_code;
    logic       key_valid;
    pinPac_t    pin_out;
    logic [2:0] digit_count;
    logic       timeout;

    modport master (output enable, key_code, key_valid,
                    input  pin_out, digit_count, timeout);
    modport slave  (input  enable, key_code, key_valid,
                    output pin_out, digit_count, timeout);
endinterface

// File: rtl/montar_pin.sv
// Buffers up to four keypad digits and emits a one-cycle PIN packet on confirm.
// Entry is abandoned on clear, on enable dropping, or after TIMEOUT_CYCLES idle cycles.
module montar_pin
    import montar_pin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input logic        clk,
    input logic        rst,
    montar_pin_if.slave bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ENTRY, SEND} state_t;

    state_t        state_q, state_d;
    pinPac_t       pin_q, pin_d;
    logic [2:0]    count_q, count_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic is_digit, is_confirm, is_clear, expired;

    assign is_digit   = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_confirm = bus.key_valid && (bus.key_code == 4'hB);
    assign is_clear   = bus.key_valid && (bus.key_code == 4'hC);
    assign expired    = (state_q == ENTRY) && !bus.key_valid && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEND: state_d = IDLE;
            IDLE, ENTRY: begin
                if (!bus.enable)     state_d = IDLE;
                else if (is_confirm) state_d = SEND;
                else if (is_clear)   state_d = IDLE;
                else if (is_digit)   state_d = ENTRY;
                else if (expired)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any move into IDLE blanks the buffer; only ENTRY accepts digits and runs the idle timer.
    always_comb begin
        pin_d        = pin_q;
        pin_d.status = 1'b0;
        count_d      = count_q;
        cnt_d        = cnt_q;
        timeout_d    = expired && bus.enable;
        case (state_d)
            IDLE: begin
                pin_d   = BLANK_PAC;
                count_d = 3'd0;
                cnt_d   = '0;
            end
            SEND: begin
                pin_d.status = 1'b1;
                cnt_d        = '0;
            end
            ENTRY: begin
                if (is_digit) begin
                    cnt_d = '0;
                    if (count_q < 3'd4) begin
                        case (count_q)
                            3'd0:    pin_d.digit1 = bus.key_code;
                            3'd1:    pin_d.digit2 = bus.key_code;
                            3'd2:    pin_d.digit3 = bus.key_code;
                            default: pin_d.digit4 = bus.key_code;
                        endcase
                        count_d = count_q + 3'd1;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pin_q     <= BLANK_PAC;
            count_q   <= 3'd0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pin_q     <= pin_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pin_out     = pin_q;
    assign bus.digit_count = count_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_montar_pin.sv
// Directed-vector bench for montar_pin with TIMEOUT_CYCLES = 8.
// Keys are driven on the falling edge and outputs sampled 1 ns after the rising edge.
module tb_montar_pin;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    montar_pin_if bus();

    montar_pin #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] digits;
    assign digits = {bus.pin_out.digit1, bus.pin_out.digit2, bus.pin_out.digit3, bus.pin_out.digit4};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] exp_dig, input logic [2:0] exp_cnt,
                            input logic exp_status, input logic exp_to);
        checkOutput({tag, ".digits"},  32'(digits),             32'(exp_dig));
        checkOutput({tag, ".count"},   32'(bus.digit_count),    32'(exp_cnt));
        checkOutput({tag, ".status"},  32'(bus.pin_out.status), 32'(exp_status));
        checkOutput({tag, ".timeout"}, 32'(bus.timeout),        32'(exp_to));
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'hF;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'hF;
        #12;
        checkAll("reset", 16'hAAAA, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Four digits and confirm
        press(4'h1); checkAll("d1", 16'h1AAA, 3'd1, 1'b0, 1'b0);
        press(4'h2); checkAll("d2", 16'h12AA, 3'd2, 1'b0, 1'b0);
        press(4'h3); checkAll("d3", 16'h123A, 3'd3, 1'b0, 1'b0);
        press(4'h4); checkAll("d4", 16'h1234, 3'd4, 1'b0, 1'b0);
        press(4'hB); checkAll("send1234", 16'h1234, 3'd4, 1'b1, 1'b0);
        tick(1);     checkAll("after1234", 16'hAAAA, 3'd0, 1'b0, 1'b0);

        // Partial PIN; a key during SEND is dropped
        press(4'h7); press(4'h8);
        press(4'hB); checkAll("send78", 16'h78AA, 3'd2, 1'b1, 1'b0);
        press(4'h5); checkAll("dropInSend", 16'hAAAA, 3'd0, 1'b0, 1'b0);

        // Fifth digit ignored
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        checkAll("fifth", 16'h1234, 3'd4, 1'b0, 1'b0);
        press(4'hB); checkAll("send5th", 16'h1234, 3'd4, 1'b1, 1'b0);
        tick(1);

        // Timeout after 8 idle cycles
        press(4'h5);
        tick(7);     checkAll("preTimeout", 16'h5AAA, 3'd1, 1'b0, 1'b0);
        tick(1);     checkAll("timeout", 16'hAAAA, 3'd0, 1'b0, 1'b1);
        tick(1);     checkAll("timeoutEnd", 16'hAAAA, 3'd0, 1'b0, 1'b0);

        // Key on the expiry cycle wins
        press(4'h5);
        tick(7);
        press(4'h6); checkAll("keyWins", 16'h56AA, 3'd2, 1'b0, 1'b0);

        // Clear then confirm sends blanks
        press(4'hC); checkAll("clear", 16'hAAAA, 3'd0, 1'b0, 1'b0);
        press(4'h3); press(4'h3); press(4'hC);
        press(4'hB); checkAll("sendCleared", 16'hAAAA, 3'd0, 1'b1, 1'b0);
        tick(1);

        // Ignored code neither changes data nor restarts the timer
        press(4'h4);
        tick(5);
        press(4'hE); checkAll("ignored", 16'h4AAA, 3'd1, 1'b0, 1'b0);
        tick(1);     checkAll("ignoredPre", 16'h4AAA, 3'd1, 1'b0, 1'b0);
        tick(1);     checkAll("ignoredTimeout", 16'hAAAA, 3'd0, 1'b0, 1'b1);

        // Confirm from IDLE
        tick(1);
        press(4'hB); checkAll("idleConfirm", 16'hAAAA, 3'd0, 1'b1, 1'b0);
        tick(1);

        // Enable dropped mid-entry
        press(4'h1); press(4'h2);
        @(negedge clk);
        bus.enable = 1'b0;
        tick(1);     checkAll("enableLow", 16'hAAAA, 3'd0, 1'b0, 1'b0);
        press(4'h3); checkAll("keyDisabled", 16'hAAAA, 3'd0, 1'b0, 1'b0);
        press(4'hB); checkAll("confirmDisabled", 16'hAAAA, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.enable = 1'b1;

        // Asynchronous reset during SEND
        press(4'h9);
        press(4'hB); checkAll("preReset", 16'h9AAA, 3'd1, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        checkAll("resetInSend", 16'hAAAA, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        press(4'h6); checkAll("afterReset", 16'h6AAA, 3'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/montar_pin.md
MONTAR_PIN -- requirements
Module: montar_pin

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000: idle clock cycles allowed between keys during entry before the buffer is discarded.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  high = lock FSM accepts PIN entry; low = keys ignored and buffer cleared.
REQ-005 key_code  input  4  key value: 0x0-0x9 digit, 0xB confirm, 0xC clear; 0xA, 0xD, 0xE, 0xF are ignored.
REQ-006 key_valid  input  1  one-cycle pulse; key_code is sampled only when key_valid=1.
REQ-007 pin_out  output  pinPac_t  digit1..digit4 (4 bits each) plus status; this is the PIN packet consumed by the password-check stage.
REQ-008 digit_count  output  3  number of digits currently buffered (0-4), for display.
REQ-009 timeout  output  1  one-cycle pulse when an entry is discarded by timeout.

Function
REQ-010 The FSM SHALL have three states: IDLE (0 digits), ENTRY (1-4 digits) and SEND (packet presented).
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 Unfilled digit positions SHALL hold 0xA (blank).
REQ-013 The first digit accepted SHALL go to digit1, the second to digit2, the third to digit3 and the fourth to digit4.
REQ-014 A digit key SHALL increment digit_count by 1, effective the cycle after the key_valid edge.
REQ-015 A digit key with digit_count=4 SHALL be ignored: digits and count unchanged, but the timeout counter is still reset.
REQ-016 IDLE + digit key -> ENTRY.
REQ-017 ENTRY or IDLE + confirm key -> SEND; in the following cycle pin_out.status=1 for exactly one cycle, with the digits as buffered (blanks included).
REQ-018 Confirm in IDLE SHALL send an all-blank packet (0xA,0xA,0xA,0xA) so the downstream check flags a failure.
REQ-019 SEND -> IDLE unconditionally after one cycle.
REQ-020 On the SEND->IDLE transition, all digits SHALL return to 0xA and digit_count to 0.
REQ-021 Keys arriving while in SEND SHALL be dropped.
REQ-022 Clear key in IDLE/ENTRY -> IDLE, with the digits blanked and count 0 the next cycle; no status, no timeout pulse.
REQ-023 Ignored key codes SHALL cause no state or data change and SHALL NOT reset the timeout counter.
REQ-024 The timeout counter SHALL run only in ENTRY and SHALL reset to 0 on every accepted digit/clear/confirm key and on entering ENTRY.
REQ-025 In ENTRY, when the counter reaches TIMEOUT_CYCLES-1 with no valid key that cycle -> IDLE, buffer blanked, timeout=1 for one cycle.
REQ-026 If key_valid coincides with counter expiry, the key SHALL win and no timeout SHALL occur.
REQ-027 The counter width SHALL be $clog2(TIMEOUT_CYCLES); it SHALL never wrap.
REQ-028 When enable=0 in IDLE/ENTRY: next state IDLE, buffer blanked, count 0, no status, no timeout, keys ignored.
REQ-029 A SEND already in progress when enable falls SHALL complete its one-cycle status pulse.
REQ-030 pin_out.status SHALL be 0 in every cycle except the single SEND output cycle.

Reset
REQ-031 While rst=0: state IDLE, digit1..digit4=0xA, pin_out.status=0, digit_count=0, timeout=0, timeout counter=0.
REQ-032 Reset SHALL act asynchronously, including mid-entry and mid-SEND; a pending status pulse is lost.
REQ-033 After rst rises, the first key SHALL be accepted on the first rising edge.

Verification
REQ-034 Keys 1,2,3,4,confirm (enable=1) -> one status pulse with digit1..4=1,2,3,4; digit_count goes 1,2,3,4, then 0 after send.
REQ-035 Keys 7,8,confirm -> packet 7,8,A,A with status=1 for one cycle; keys 1,2,3,4,5,confirm -> packet 1,2,3,4 (fifth digit dropped).
REQ-036 Key 5, then no key for TIMEOUT_CYCLES (parameter set to 8) -> timeout pulse on the 8th idle cycle, digits A,A,A,A, no status; key exactly on the 8th cycle -> no timeout.
REQ-037 Keys 3,3,clear,confirm -> packet A,A,A,A with status=1; ignored code 0xE mid-entry -> count and timer unaffected.
REQ-038 enable dropped after 2 digits -> buffer blank and count 0 the next cycle, keys ignored while low; rst=0 during SEND -> status=0 immediately, all outputs at reset values.
